note_sprite_blitter: RTL and testbench



---
 rtl/taiko_draw_pkg.sv | 68 ++++++
 rtl/note_sprite_blitter_if.sv | 40 ++++
 rtl/sprite_raster_counter.sv | 40 ++++
 rtl/note_sprite_blitter.sv | 146 ++++++++++++++
 tb/tb_note_sprite_blitter.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/taiko_draw_pkg.sv
// Shared encodings for the note lane draw path.
// Sprite kinds, sizes, ROM selects and walker states.
package taiko_draw_pkg;

    localparam int SMALL_DIM = 9;
    localparam int BIG_DIM   = 13;
    localparam int DIM_W     = 4;
    localparam int ADDR_W    = 8;

    localparam logic [2:0] KIND_ERASE  = 3'd0;
    localparam logic [2:0] KIND_RED_S  = 3'd1;
    localparam logic [2:0] KIND_BLUE_S = 3'd2;
    localparam logic [2:0] KIND_RED_B  = 3'd3;
    localparam logic [2:0] KIND_BLUE_B = 3'd4;

    localparam logic [1:0] ROM_RED_S  = 2'd0;
    localparam logic [1:0] ROM_BLUE_S = 2'd1;
    localparam logic [1:0] ROM_RED_B  = 2'd2;
    localparam logic [1:0] ROM_BLUE_B = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WALK,
        ST_DRAIN,
        ST_FLUSH
    } state_e;

    typedef struct packed {
        logic             valid;
        logic             erase;
        logic [DIM_W-1:0] col;
        logic [DIM_W-1:0] row;
    } pix_t;

    // Kinds 5..7 fall through to erase.
    function automatic logic kind_is_erase(
        input logic [2:0] k
    );
        return !(k == KIND_RED_S  ||
                 k == KIND_BLUE_S ||
                 k == KIND_RED_B  ||
                 k == KIND_BLUE_B);
    endfunction

    function automatic logic [DIM_W-1:0] kind_dim(
        input logic [2:0] k
    );
        unique case (1'b1)
            (k == KIND_RED_S),
            (k == KIND_BLUE_S):
                return DIM_W'(SMALL_DIM);
            default:
                return DIM_W'(BIG_DIM);
        endcase
    endfunction

    function automatic logic [1:0] kind_rom_sel(
        input logic [2:0] k
    );
        unique case (1'b1)
            (k == KIND_BLUE_S): return ROM_BLUE_S;
            (k == KIND_RED_B):  return ROM_RED_B;
            (k == KIND_BLUE_B): return ROM_BLUE_B;
            default:            return ROM_RED_S;
        endcase
    endfunction

endpackage

// File: rtl/note_sprite_blitter_if.sv
// Draw request, face ROM port and VGA plot port of the blitter.
// master: draw FSM / ROMs / VGA side; slave: the blitter.
interface note_sprite_blitter_if #(
    parameter int NUM_SLOTS = 15,
    parameter int X_W       = 8,
    parameter int Y_W       = 7,
    parameter int COLOUR_W  = 3,
    parameter int SLOT_W    = $clog2(NUM_SLOTS)
);
    logic                     start;
    logic [SLOT_W-1:0]        slot;
    logic [NUM_SLOTS*X_W-1:0] slot_x;
    logic [NUM_SLOTS*3-1:0]   slot_kind;
    logic [COLOUR_W-1:0]      bg_colour;
    logic [1:0]               rom_sel;
    logic [7:0]               rom_addr;
    logic [COLOUR_W-1:0]      rom_data;
    logic [X_W-1:0]           out_x;
    logic [Y_W-1:0]           out_y;
    logic [COLOUR_W-1:0]      out_colour;
    logic                     plot;
    logic                     busy;
    logic                     done;

    modport master (
        output start, slot, slot_x, slot_kind,
        output bg_colour, rom_data,
        input  rom_sel, rom_addr,
        input  out_x, out_y, out_colour,
        input  plot, busy, done
    );

    modport slave (
        input  start, slot, slot_x, slot_kind,
        input  bg_colour, rom_data,
        output rom_sel, rom_addr,
        output out_x, out_y, out_colour,
        output plot, busy, done
    );
endinterface

// File: rtl/sprite_raster_counter.sv
// Square raster walker: col/row/linear address without a multiplier.
// The address simply counts, so it always equals row*dim+col.
module sprite_raster_counter
    import taiko_draw_pkg::*;
(
    input  logic              CLK,
    input  logic              reset,
    input  logic              clear,
    input  logic              step,
    input  logic [DIM_W-1:0]  dim,
    output logic [DIM_W-1:0]  col,
    output logic [DIM_W-1:0]  row,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);
    logic [DIM_W-1:0] dim_m1;

    assign dim_m1 = dim - DIM_W'(1);
    assign last   = (col == dim_m1) && (row == dim_m1);

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            col  <= '0;
            row  <= '0;
            addr <= '0;
        end else if (clear) begin
            col  <= '0;
            row  <= '0;
            addr <= '0;
        end else if (step) begin
            addr <= addr + ADDR_W'(1);
            if (col == dim_m1) begin
                col <= '0;
                row <= row + DIM_W'(1);
            end else begin
                col <= col + DIM_W'(1);
            end
        end
    end
endmodule

// File: rtl/note_sprite_blitter.sv
// Note lane sprite engine: walks one slot's sprite raster and emits
// one clipped, colour-keyed plot per cycle behind a 1-cycle ROM.
module note_sprite_blitter
    import taiko_draw_pkg::*;
#(
    parameter int NUM_SLOTS = 15,
    parameter int X_W       = 8,
    parameter int Y_W       = 7,
    parameter int COLOUR_W  = 3,
    parameter int LANE_Y    = 110,
    parameter logic [COLOUR_W-1:0] TRANSPARENT_KEY = '0,
    parameter int SLOT_W    = $clog2(NUM_SLOTS)
) (
    input logic CLK,
    input logic reset,
    note_sprite_blitter_if.slave bus
);
    state_e state, state_nxt;
    logic   accept, step;

    logic [X_W-1:0]   sel_x, x_q;
    logic [2:0]       sel_kind, kind_q;
    logic [DIM_W-1:0] dim_q;

    logic [DIM_W-1:0]  col, row;
    logic [ADDR_W-1:0] addr;
    logic              last;

    pix_t s1;

    logic [X_W:0]          x_sum;
    logic [Y_W:0]          y_sum;
    logic                  clip, opaque;
    logic [X_W-1:0]        x_r;
    logic [Y_W-1:0]        y_r;
    logic [COLOUR_W-1:0]   c_r;
    logic                  plot_r, done_r;

    always_comb begin
        sel_x    = '0;
        sel_kind = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (bus.slot == SLOT_W'(i)) begin
                sel_x    = bus.slot_x[i*X_W +: X_W];
                sel_kind = bus.slot_kind[i*3 +: 3];
            end
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        step      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (bus.start &&
                    32'(bus.slot) < NUM_SLOTS) begin
                    accept    = 1'b1;
                    state_nxt = ST_WALK;
                end
            end
            ST_WALK: begin
                step = 1'b1;
                if (last) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: state_nxt = ST_FLUSH;
            ST_FLUSH: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            x_q    <= '0;
            kind_q <= '0;
            dim_q  <= '0;
        end else if (accept) begin
            x_q    <= sel_x;
            kind_q <= sel_kind;
            dim_q  <= kind_dim(sel_kind);
        end
    end

    sprite_raster_counter u_raster (
        .CLK   (CLK),
        .reset (reset),
        .clear (accept),
        .step  (step),
        .dim   (dim_q),
        .col   (col),
        .row   (row),
        .addr  (addr),
        .last  (last)
    );

    // Stage 1 lines the pixel position up with the ROM read latency.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            s1 <= '0;
        end else begin
            s1.valid <= (state == ST_WALK);
            s1.erase <= kind_is_erase(kind_q);
            s1.col   <= col;
            s1.row   <= row;
        end
    end

    assign x_sum  = {1'b0, x_q} + (X_W+1)'(s1.col);
    assign y_sum  = (Y_W+1)'(LANE_Y) + (Y_W+1)'(s1.row);
    assign clip   = x_sum[X_W] | y_sum[Y_W];
    assign opaque = s1.erase |
                    (bus.rom_data != TRANSPARENT_KEY);

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            x_r    <= '0;
            y_r    <= '0;
            c_r    <= '0;
            plot_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            plot_r <= s1.valid & ~clip & opaque;
            done_r <= (state == ST_FLUSH);
            if (s1.valid) begin
                x_r <= x_sum[X_W-1:0];
                y_r <= y_sum[Y_W-1:0];
                c_r <= s1.erase ? bus.bg_colour
                                : bus.rom_data;
            end
        end
    end

    assign bus.rom_addr   = addr;
    assign bus.rom_sel    = kind_rom_sel(kind_q);
    assign bus.out_x      = x_r;
    assign bus.out_y      = y_r;
    assign bus.out_colour = c_r;
    assign bus.plot       = plot_r;
    assign bus.done       = done_r;
    assign bus.busy       = (state != ST_IDLE);
endmodule

// File: tb/tb_note_sprite_blitter.sv
// Directed bench for note_sprite_blitter with a 1-cycle face ROM model.
// Timing is measured in edges relative to the accept edge E0.
module tb_note_sprite_blitter;
    import taiko_draw_pkg::*;

    logic CLK = 1'b0;
    logic reset;

    note_sprite_blitter_if #(
        .NUM_SLOTS(15), .X_W(8), .Y_W(7), .COLOUR_W(3)
    ) bus ();

    note_sprite_blitter #(
        .NUM_SLOTS(15), .X_W(8), .Y_W(7), .COLOUR_W(3),
        .LANE_Y(110), .TRANSPARENT_KEY(3'b000)
    ) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus)
    );

    always #10 CLK = ~CLK;

    int total = 0;
    int passed = 0;
    int fails = 0;
    int cur_x, cur_kind, cur_bg;
    bit zero0 = 1'b0;

    int nplots, first_rel, last_rel;
    int first_x, first_y, last_x, last_y;
    int minx, maxx, miny, maxy;
    int bad_col, ndone, done_rel, busy_bad;
    int sel0, a0, a1, plot_at_rst, busy_at_rst;

    function automatic logic [2:0] rom_fn(input int a);
        if (zero0 && a == 0) return 3'd0;
        return 3'((a % 7) + 1);
    endfunction

    always @(posedge CLK)
        bus.rom_data <= rom_fn(int'(bus.rom_addr));

    task automatic chk(input string tag, input int obs,
                       input int want);
        total++;
        assert (obs === want) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d",
                   tag, obs, want);
        end
    endtask

    task automatic set_slot(input int s, input int x,
                            input int k);
        bus.slot_x[s*8 +: 8]    = 8'(x);
        bus.slot_kind[s*3 +: 3] = 3'(k);
        cur_x    = x;
        cur_kind = k;
    endtask

    // Caller is at a negedge; start is seen by the next edge (E0).
    task automatic run(input int s, input int nexp,
                       input int len, input int mid_rel,
                       input int rst_rel);
        nplots = 0; first_rel = -1; last_rel = -1;
        first_x = -1; first_y = -1; last_x = -1; last_y = -1;
        minx = 999; maxx = -1; miny = 999; maxy = -1;
        bad_col = 0; ndone = 0; done_rel = -1; busy_bad = 0;
        sel0 = -1; a0 = -1; a1 = -1;
        plot_at_rst = -1; busy_at_rst = -1;
        bus.slot  = 4'(s);
        bus.start = 1'b1;
        @(posedge CLK);
        for (int rel = 0; rel < len; rel++) begin
            @(negedge CLK);
            bus.start = (rel == mid_rel);
            if (rel == mid_rel) begin
                bus.slot      = 4'd5;
                bus.slot_x    = ~bus.slot_x;
                bus.slot_kind = ~bus.slot_kind;
            end
            if (rst_rel >= 0 && rel == rst_rel + 1)
                reset = 1'b0;
            if (rel == 0) begin
                sel0 = int'(bus.rom_sel);
                a0   = int'(bus.rom_addr);
            end
            if (rel == 1) a1 = int'(bus.rom_addr);
            if (bus.plot === 1'b1) begin
                int px, py, col, row, dim, want;
                bit er;
                px = int'(bus.out_x);
                py = int'(bus.out_y);
                if (nplots == 0) begin
                    first_rel = rel; first_x = px; first_y = py;
                end
                nplots++;
                last_rel = rel; last_x = px; last_y = py;
                if (px < minx) minx = px;
                if (px > maxx) maxx = px;
                if (py < miny) miny = py;
                if (py > maxy) maxy = py;
                col = (px - cur_x) & 255;
                row = py - 110;
                dim = (cur_kind == 1 || cur_kind == 2) ? 9 : 13;
                er  = !(cur_kind >= 1 && cur_kind <= 4);
                want = er ? cur_bg : int'(rom_fn(row*dim + col));
                if (int'(bus.out_colour) != want) bad_col++;
            end
            if (bus.done === 1'b1) begin
                ndone++;
                done_rel = rel;
            end
            if (rst_rel < 0 &&
                bus.busy !== (rel <= nexp + 1))
                busy_bad++;
            if (rel == rst_rel) begin
                reset = 1'b1;
                #1;
                plot_at_rst = int'(bus.plot);
                busy_at_rst = int'(bus.busy);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 1'b0;
        bus.slot = '0;
        bus.slot_x = '0;
        bus.slot_kind = '0;
        bus.bg_colour = '0;
        cur_bg = 0;
        repeat (3) @(negedge CLK);
        chk("rst_plot", int'(bus.plot), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_addr", int'(bus.rom_addr), 0);
        chk("rst_sel", int'(bus.rom_sel), 0);
        chk("rst_xyc", int'({bus.out_x, bus.out_y,
                             bus.out_colour}), 0);
        reset = 1'b0;
        @(negedge CLK);

        set_slot(0, 20, 1);
        run(0, 81, 90, -1, -1);
        chk("t1_n", nplots, 81);
        chk("t1_first_rel", first_rel, 2);
        chk("t1_first_x", first_x, 20);
        chk("t1_first_y", first_y, 110);
        chk("t1_last_rel", last_rel, 82);
        chk("t1_last_x", last_x, 28);
        chk("t1_last_y", last_y, 118);
        chk("t1_done_rel", done_rel, 83);
        chk("t1_ndone", ndone, 1);
        chk("t1_busy", busy_bad, 0);
        chk("t1_colour", bad_col, 0);
        chk("t1_sel", sel0, 0);
        chk("t1_addr0", a0, 0);
        chk("t1_addr1", a1, 1);

        cur_bg = 7;
        bus.bg_colour = 3'b111;
        set_slot(2, 40, 0);
        run(2, 169, 175, -1, -1);
        chk("t2_n", nplots, 169);
        chk("t2_minx", minx, 40);
        chk("t2_maxx", maxx, 52);
        chk("t2_miny", miny, 110);
        chk("t2_maxy", maxy, 122);
        chk("t2_colour", bad_col, 0);
        chk("t2_done_rel", done_rel, 171);
        chk("t2_busy", busy_bad, 0);

        zero0 = 1'b1;
        set_slot(1, 60, 2);
        run(1, 81, 90, -1, -1);
        zero0 = 1'b0;
        chk("t3_n", nplots, 80);
        chk("t3_first_rel", first_rel, 3);
        chk("t3_last_rel", last_rel, 82);
        chk("t3_done_rel", done_rel, 83);
        chk("t3_sel", sel0, 1);
        chk("t3_colour", bad_col, 0);

        set_slot(14, 250, 3);
        run(14, 169, 175, -1, -1);
        chk("t4_n", nplots, 78);
        chk("t4_minx", minx, 250);
        chk("t4_maxx", maxx, 255);
        chk("t4_last_rel", last_rel, 163);
        chk("t4_done_rel", done_rel, 171);
        chk("t4_sel", sel0, 2);
        chk("t4_colour", bad_col, 0);

        set_slot(3, 0, 4);
        run(3, 169, 175, 50, -1);
        chk("t5_n", nplots, 169);
        chk("t5_ndone", ndone, 1);
        chk("t5_done_rel", done_rel, 171);
        chk("t5_maxx", maxx, 12);
        chk("t5_sel", sel0, 3);
        chk("t5_colour", bad_col, 0);
        chk("t5_busy", busy_bad, 0);

        run(15, -2, 30, -1, -1);
        chk("t5b_ndone", ndone, 0);
        chk("t5b_n", nplots, 0);
        chk("t5b_busy", busy_bad, 0);

        set_slot(4, 30, 3);
        run(4, 169, 180, -1, 42);
        chk("t6_n", nplots, 41);
        chk("t6_plot_rst", plot_at_rst, 0);
        chk("t6_busy_rst", busy_at_rst, 0);
        chk("t6_ndone", ndone, 0);

        set_slot(0, 20, 1);
        run(0, 81, 90, -1, -1);
        chk("t6b_n", nplots, 81);
        chk("t6b_first_x", first_x, 20);
        chk("t6b_done_rel", done_rel, 83);
        chk("t6b_colour", bad_col, 0);

        set_slot(5, 100, 2);
        run(5, 81, 84, -1, -1);
        chk("t7a_done_rel", done_rel, 83);
        set_slot(6, 120, 1);
        run(6, 81, 90, -1, -1);
        chk("t7b_first_rel", first_rel, 2);
        chk("t7b_first_x", first_x, 120);
        chk("t7b_n", nplots, 81);
        chk("t7b_done_rel", done_rel, 83);

        cur_bg = 5;
        bus.bg_colour = 3'b101;
        set_slot(7, 10, 7);
        run(7, 169, 175, -1, -1);
        chk("t8_n", nplots, 169);
        chk("t8_colour", bad_col, 0);
        chk("t8_sel", sel0, 0);
        chk("t8_done_rel", done_rel, 171);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
